// File: rtl/coord_link_pkg.sv
// Shared constants for the host coordinate link frame (header bytes, frame size,
// checksum span) and the frame FSM state type used by the transmit side.
package coord_link_pkg;

    localparam logic [7:0] HDR0_DEF    = 8'hAA;
    localparam logic [7:0] HDR1_DEF    = 8'h55;
    localparam int         FRAME_BYTES = 16;
    localparam int         CHK_FIRST   = 2;
    localparam int         CHK_LAST    = 14;
    localparam int         IDX_W       = 4;
    localparam int         BAUD_CNT_W  = 16;

    typedef enum logic [2:0] {
        FS_IDLE = 3'd0,
        FS_SEND = 3'd1,
        FS_WAIT = 3'd2,
        FS_LAST = 3'd3,
        FS_DONE = 3'd4
    } frame_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser. A start request in the final stop-bit cycle chains the
// next byte with no idle gap; last_cycle gives the frame FSM one cycle of warning.
import coord_link_pkg::*;

module uart_byte_tx #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       last_cycle
);

    localparam logic [BAUD_CNT_W-1:0] CNT_MAX = BAUD_CNT_W'(DIV - 1);
    localparam logic [BAUD_CNT_W-1:0] CNT_PRE = BAUD_CNT_W'(DIV - 2);
    localparam logic [3:0]            BIT_D7   = 4'd8;
    localparam logic [3:0]            BIT_STOP = 4'd9;

    if (DIV < 2 || DIV > 65535) begin : g_bad_div
        $error("uart_byte_tx: DIV=%0d outside the supported range 2..65535", DIV);
    end

    logic [BAUD_CNT_W-1:0] r_cnt;
    logic [3:0]            r_bit;
    logic [7:0]            r_shift;
    logic                  r_tx;
    logic                  r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_shift <= data;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                if (r_bit == BIT_STOP) begin
                    r_busy <= 1'b0;
                    r_tx   <= 1'b1;
                    r_bit  <= '0;
                end else begin
                    r_bit <= r_bit + 4'd1;
                    // Leaving bit k (k<8) puts data bit k on the line; leaving d7 starts the stop bit.
                    if (r_bit == BIT_D7) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                    end
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign last_cycle = r_busy && (r_bit == BIT_STOP) && (r_cnt == CNT_PRE);

endmodule

// File: rtl/coord_uart_tx.sv
// Coordinate frame transmitter: latches x/y/z/status on accept and sends
// HDR0 HDR1 x y z status CHK (MSB byte first) as one gap-free 8N1 burst.
import coord_link_pkg::*;

module coord_uart_tx #(
    parameter int         CLK_FREQ = 50_000_000,
    parameter int         BAUD     = 115_200,
    parameter logic [7:0] HDR0     = HDR0_DEF,
    parameter logic [7:0] HDR1     = HDR1_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        send,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    input  logic [7:0]  status,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    // state | meaning
    // IDLE  | line idle, send accepted (operands latched on the accept edge)
    // SEND  | hand byte idx to the serialiser, fold it into CHK when in range
    // WAIT  | serialiser shifting byte idx
    // LAST  | final stop-bit cycle of byte 15
    // DONE  | done pulse; send accepted here too

    localparam int                DIV          = CLK_FREQ / BAUD;
    localparam logic [IDX_W-1:0]  IDX_CHK_LO   = IDX_W'(CHK_FIRST);
    localparam logic [IDX_W-1:0]  IDX_CHK_HI   = IDX_W'(CHK_LAST);
    localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(FRAME_BYTES - 1);

    frame_state_t     r_state;
    frame_state_t     w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [7:0]       r_chk;
    logic [7:0]       w_chk_nxt;
    logic [31:0]      r_x;
    logic [31:0]      r_y;
    logic [31:0]      r_z;
    logic [7:0]       r_status;
    logic [7:0]       w_byte;
    logic             w_accept;
    logic             w_start;
    logic             w_ser_busy;
    logic             w_ser_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FS_IDLE;
            r_idx    <= '0;
            r_chk    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_z      <= '0;
            r_status <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_chk   <= w_chk_nxt;
            if (w_accept) begin
                r_x      <= x;
                r_y      <= y;
                r_z      <= z;
                r_status <= status;
            end
        end
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:    w_byte = HDR0;
            4'd1:    w_byte = HDR1;
            4'd2:    w_byte = r_x[31:24];
            4'd3:    w_byte = r_x[23:16];
            4'd4:    w_byte = r_x[15:8];
            4'd5:    w_byte = r_x[7:0];
            4'd6:    w_byte = r_y[31:24];
            4'd7:    w_byte = r_y[23:16];
            4'd8:    w_byte = r_y[15:8];
            4'd9:    w_byte = r_y[7:0];
            4'd10:   w_byte = r_z[31:24];
            4'd11:   w_byte = r_z[23:16];
            4'd12:   w_byte = r_z[15:8];
            4'd13:   w_byte = r_z[7:0];
            4'd14:   w_byte = r_status;
            default: w_byte = r_chk;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_chk_nxt   = r_chk;
        w_accept    = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            FS_IDLE, FS_DONE: begin
                w_state_nxt = FS_IDLE;
                if (send) begin
                    w_accept    = 1'b1;
                    w_state_nxt = FS_SEND;
                    w_idx_nxt   = '0;
                    w_chk_nxt   = '0;
                end
            end
            FS_SEND: begin
                w_start     = 1'b1;
                w_state_nxt = FS_WAIT;
                if (r_idx >= IDX_CHK_LO && r_idx <= IDX_CHK_HI) begin
                    w_chk_nxt = r_chk + w_byte;
                end
            end
            FS_WAIT: begin
                // last_cycle leads the end of the stop bit by one, so SEND lands in its final cycle.
                if (w_ser_last) begin
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = FS_LAST;
                    end else begin
                        w_state_nxt = FS_SEND;
                        w_idx_nxt   = r_idx + 1'b1;
                    end
                end
            end
            FS_LAST: begin
                w_state_nxt = FS_DONE;
            end
            default: begin
                w_state_nxt = FS_IDLE;
            end
        endcase
    end

    uart_byte_tx #(
        .DIV (DIV)
    ) u_byte_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (w_start),
        .data       (w_byte),
        .tx         (tx),
        .busy       (w_ser_busy),
        .last_cycle (w_ser_last)
    );

    assign busy = (r_state == FS_SEND) || (r_state == FS_WAIT) || (r_state == FS_LAST);
    assign done = (r_state == FS_DONE);

endmodule
